// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: synchronises and edge-detects external interrupt lines,
// latches pending requests and presents one request at a time (one-hot) to
// the CP0 exception block, tracking it through acknowledge and ERET.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   irq_in        raw asynchronous interrupt lines, active high
//   mask_in       per-source block bits (1 = blocked)
//   exp_block     global hold-off (CP0 Status[0])
//   has_exp       CP0 acknowledge of the presented request
//   is_eret       ERET decode, ends the service phase
//   exp_src       one-hot request to CP0 expSrc inputs (registered)
//   pending       latched pending bits
//   active_id     index of the source presented or in service
//   busy          high while a request is presented or in service
//   req_timeout   sticky flag, an acknowledge timeout has occurred
//   svc_count     per-source 16-bit service counters (IRQ_SERVICE_STATS_EN only)
//
// Optional feature macro: IRQ_SERVICE_STATS_EN.
module irq_source_ctrl #(
  parameter int unsigned NSRC        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REQ_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] mask_in,
  input  logic            exp_block,
  input  logic            has_exp,
  input  logic            is_eret,
  output logic [NSRC-1:0] exp_src,
  output logic [NSRC-1:0] pending,
  output logic [1:0]      active_id,
  output logic            busy,
  output logic            req_timeout
`ifdef IRQ_SERVICE_STATS_EN
  ,
  output logic [NSRC*16-1:0] svc_count
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [SYNC_STAGES-1:0][NSRC-1:0]   sync_q;
  logic [NSRC-1:0]                    prev_q;
  logic [NSRC-1:0]                    rise;
  logic [NSRC-1:0]                    eligible;
  logic [NSRC-1:0]                    clr;
  logic [NSRC-1:0]                    pend_q, pend_d;
  logic [NSRC-1:0]                    exp_q, exp_d;
  logic [ID_W-1:0]                    id_q, id_d, top_id;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               to_q, to_d;
  logic                               busy_q, busy_d;

  function automatic logic [NSRC-1:0] onehot(input logic [ID_W-1:0] id);
    return NSRC'(1) << id;
  endfunction

  // Input synchroniser plus previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign eligible = pend_q & ~mask_in & {NSRC{~exp_block}};

  // Highest eligible index wins.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i]) top_id = ID_W'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    exp_d   = '0;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQ;
          id_d    = top_id;
          cnt_d   = '0;
          exp_d   = onehot(top_id);
        end
      end
      ST_REQ: begin
        if (has_exp) begin
          clr     = onehot(id_q);
          state_d = ST_SVC;
        end else if (mask_in[id_q] || exp_block) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(REQ_TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          exp_d = onehot(id_q);
        end
      end
      ST_SVC: begin
        if (is_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    // A new edge on the source being acknowledged keeps it pending.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      exp_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      exp_q   <= exp_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign exp_src     = exp_q;
  assign pending     = pend_q;
  assign active_id   = id_q;
  assign busy        = busy_q;
  assign req_timeout = to_q;

`ifdef IRQ_SERVICE_STATS_EN
  logic [NSRC-1:0][15:0] svc_q;

  // Saturating per-source count of REQ->SERVICE transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      svc_q <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (clr[i] && (svc_q[i] != 16'hFFFF)) svc_q[i] <= svc_q[i] + 16'd1;
      end
    end
  end

  assign svc_count = svc_q;
`endif

endmodule
